// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the traffic light controller and its environment.
// The pedestrian request/walk pair exists only when PED_XING_EN is defined.
interface traffic_light_ctrl_if;
    logic       tick;
    logic       ew_car;
    logic [2:0] ns_lights;
    logic [2:0] ew_lights;
    logic [2:0] phase;
`ifdef PED_XING_EN
    logic       ped_req;
    logic       ped_walk;

    modport master (
        output tick, ew_car, ped_req,
        input  ns_lights, ew_lights, phase, ped_walk
    );
    modport slave (
        input  tick, ew_car, ped_req,
        output ns_lights, ew_lights, phase, ped_walk
    );
`else
    modport master (
        output tick, ew_car,
        input  ns_lights, ew_lights, phase
    );
    modport slave (
        input  tick, ew_car,
        output ns_lights, ew_lights, phase
    );
`endif
endinterface

// File: rtl/traffic_light_ctrl.sv
// Actuated two-road intersection controller: Moore FSM timed by a tick strobe, NS rests in green.
// Define PED_XING_EN to add the pedestrian latch, the WALK phase and the ped_req/ped_walk signals.
module traffic_light_ctrl #(
    parameter int unsigned GREEN_TIME  = 10,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned WALK_TIME   = 5,
    parameter int unsigned TIMER_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    traffic_light_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5,
        WALK = 3'd6
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [TIMER_W-1:0] GREEN_LAST  = TIMER_W'(GREEN_TIME - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_TIME - 1);
    localparam logic [TIMER_W-1:0] WALK_LAST   = TIMER_W'(WALK_TIME - 1);

    state_t             state_q, state_d, nxt;
    logic [TIMER_W-1:0] timer_q, timer_d, last;
    logic [2:0]         ns_l, ew_l;
    logic               illegal;
`ifdef PED_XING_EN
    logic               ped_q, ped_d;
`endif

    always_comb begin
        case (state_q)
            NS_G, EW_G: last = GREEN_LAST;
            NS_Y, EW_Y: last = YELLOW_LAST;
            WALK:       last = WALK_LAST;
            default:    last = ALLRED_LAST;
        endcase
    end

    // Decode and successor of the current phase; nxt is taken only on an exiting tick.
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        nxt     = state_q;
        ns_l    = RED;
        ew_l    = RED;
        illegal = 1'b0;
        case (state_q)
            NS_G: begin
                ns_l = GRN;
                nxt  = bus.ew_car ? NS_Y : NS_G;
            end
            NS_Y: begin
                ns_l = YEL;
                nxt  = AR1;
            end
            AR1:  nxt = EW_G;
            EW_G: begin
                ew_l = GRN;
                nxt  = EW_Y;
            end
            EW_Y: begin
                ew_l = YEL;
                nxt  = AR2;
            end
`ifdef PED_XING_EN
            AR2:  nxt = ped_q ? WALK : NS_G;
            WALK: nxt = NS_G;
`else
            AR2:  nxt = NS_G;
`endif
            default: illegal = 1'b1;
        endcase
    end

    // An NS_G exit without ew_car keeps state and timer, which is what saturates the timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (illegal) begin
            state_d = AR2;
        end else if (bus.tick) begin
            if (timer_q == last) state_d = nxt;
            else                 timer_d = timer_q + 1'b1;
        end
        if (state_d != state_q) timer_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NS_G;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

`ifdef PED_XING_EN
    // A request arriving on the WALK-entry cycle is kept for the following crossing.
    always_comb begin
        ped_d = ped_q | bus.ped_req;
        if (state_d == WALK && state_q != WALK) ped_d = bus.ped_req;
    end

    always_ff @(posedge clk) begin
        if (rst) ped_q <= 1'b0;
        else     ped_q <= ped_d;
    end

    assign bus.ped_walk = (state_q == WALK);
`endif

    assign bus.ns_lights = ns_l;
    assign bus.ew_lights = ew_l;
    assign bus.phase     = state_q;
endmodule
